// File: rtl/mips_decls_p.sv
// Shared MIPS controller declarations: opcodes, function codes, ALU op classes,
// multicycle FSM states and the per-state control vector.
package mips_decls_p;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b
    } opcode_t;

    typedef logic [5:0] funct_t;

    localparam funct_t F_JR = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        JALEX   = 4'd12,
        JREX    = 4'd13,
        BNEEX   = 4'd14,
        FAULT   = 4'd15
    } statetype_t;

    // ready_gated marks states whose write strobes only fire in the mem_ready cycle
    typedef struct packed {
        logic       mem_req;
        logic       pcwrite;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic       jal;
        logic       branch;
        logic       branch_ne;
        logic       ready_gated;
        logic       fault;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Combinational state -> datapath control decode for the multicycle controller.
module mc_outdec
    import mips_decls_p::*;
(
    input  statetype_t i_state,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            FETCH: begin
                o_ctrl.mem_req     = 1'b1;
                o_ctrl.pcwrite     = 1'b1;
                o_ctrl.irwrite     = 1'b1;
                o_ctrl.ready_gated = 1'b1;
                o_ctrl.alusrcb     = 2'b01;
                o_ctrl.aluop       = ALUOP_ADD;
            end
            DECODE: o_ctrl.alusrcb = 2'b11;
            MEMADR: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = 2'b10;
            end
            MEMRD: begin
                o_ctrl.mem_req = 1'b1;
                o_ctrl.iord    = 1'b1;
            end
            MEMWB: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.memtoreg = 1'b1;
            end
            MEMWR: begin
                o_ctrl.mem_req     = 1'b1;
                o_ctrl.iord        = 1'b1;
                o_ctrl.memwrite    = 1'b1;
                o_ctrl.ready_gated = 1'b1;
            end
            RTYPEEX: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.regdst   = 1'b1;
            end
            BEQEX, BNEEX: begin
                o_ctrl.alusrca   = 1'b1;
                o_ctrl.aluop     = ALUOP_SUB;
                o_ctrl.pcsrc     = 2'b01;
                o_ctrl.branch    = 1'b1;
                o_ctrl.branch_ne = (i_state == BNEEX);
            end
            ADDIEX: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = 2'b10;
            end
            ADDIWB: o_ctrl.regwrite = 1'b1;
            JEX: begin
                o_ctrl.pcsrc   = 2'b10;
                o_ctrl.pcwrite = 1'b1;
            end
            JALEX: begin
                o_ctrl.pcsrc    = 2'b10;
                o_ctrl.pcwrite  = 1'b1;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.jal      = 1'b1;
            end
            JREX: begin
                o_ctrl.pcsrc   = 2'b11;
                o_ctrl.pcwrite = 1'b1;
            end
            FAULT: o_ctrl.fault = 1'b1;
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main decoder FSM with memory handshake, wait timeout and sticky fault.
// Define MC_MAINDEC_BNE_EN to decode BNE; otherwise BNE is treated as illegal.
module mc_maindec
    import mips_decls_p::*;
#(
    parameter int MEM_TIMEOUT = 16
)
(
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_pcwrite,
    output logic       o_irwrite,
    output logic       o_regwrite,
    output logic       o_memwrite,
    output logic       o_iord,
    output logic       o_memtoreg,
    output logic       o_regdst,
    output logic       o_alusrca,
    output logic       o_jal,
    output logic       o_pcen,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_pcsrc,
    output logic [1:0] o_aluop,
    output logic       o_fault,
    output logic [3:0] o_state
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    statetype_t       r_state;
    statetype_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    ctrl_t            w_ctrl;
    logic             w_timeout;
    logic             w_gate;

    mc_outdec u_outdec (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    // mem_ready in the last allowed wait cycle still completes the access
    assign w_timeout = (MEM_TIMEOUT != 0) && w_ctrl.mem_req && !i_mem_ready && (r_cnt == CNT_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH: begin
                if (i_mem_ready)    w_next = DECODE;
                else if (w_timeout) w_next = FAULT;
            end
            DECODE: begin
                case (i_opcode)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = (i_funct == F_JR) ? JREX : RTYPEEX;
                    OP_BEQ:       w_next = BEQEX;
                    OP_ADDI:      w_next = ADDIEX;
                    OP_J:         w_next = JEX;
                    OP_JAL:       w_next = JALEX;
`ifdef MC_MAINDEC_BNE_EN
                    OP_BNE:       w_next = BNEEX;
`endif
                    default:      w_next = FAULT;
                endcase
            end
            MEMADR:  w_next = (i_opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                if (i_mem_ready)    w_next = MEMWB;
                else if (w_timeout) w_next = FAULT;
            end
            MEMWR: begin
                if (i_mem_ready)    w_next = FETCH;
                else if (w_timeout) w_next = FAULT;
            end
            RTYPEEX: w_next = ALUWB;
            ADDIEX:  w_next = ADDIWB;
            FAULT:   w_next = FAULT;
            default: w_next = FETCH;
        endcase
    end

    always_comb begin
        if (i_mem_ready || (w_next != r_state))
            w_cnt_next = '0;
        else if (w_ctrl.mem_req && (r_cnt != '1))
            w_cnt_next = r_cnt + CNT_W'(1);
        else
            w_cnt_next = r_cnt;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign w_gate = w_ctrl.ready_gated ? i_mem_ready : 1'b1;

    assign o_mem_req  = w_ctrl.mem_req;
    assign o_pcwrite  = w_ctrl.pcwrite & w_gate;
    assign o_irwrite  = w_ctrl.irwrite & w_gate;
    assign o_memwrite = w_ctrl.memwrite & w_gate;
    assign o_regwrite = w_ctrl.regwrite;
    assign o_iord     = w_ctrl.iord;
    assign o_memtoreg = w_ctrl.memtoreg;
    assign o_regdst   = w_ctrl.regdst;
    assign o_alusrca  = w_ctrl.alusrca;
    assign o_jal      = w_ctrl.jal;
    assign o_pcen     = o_pcwrite | (w_ctrl.branch & (i_zero ^ w_ctrl.branch_ne));
    assign o_alusrcb  = w_ctrl.alusrcb;
    assign o_pcsrc    = w_ctrl.pcsrc;
    assign o_aluop    = w_ctrl.aluop;
    assign o_fault    = w_ctrl.fault;
    assign o_state    = r_state;

endmodule

// File: doc/mc_maindec.md
Name: mc_maindec

Overview:
- Multicycle successor to the single-cycle MIPS main decoder: a Moore FSM sequencing FETCH/DECODE/EXECUTE/MEM/WB for one instruction over several cycles.
- Adds a memory request/ready handshake, a bounded memory-wait timeout, and a sticky fault state for illegal opcodes instead of 'x outputs.
- Sits in the multicycle controller beside aludec; drives the shared multicycle datapath.

Parameters:
- MEM_TIMEOUT, 16, max cycles waiting for mem_ready before fault; 0 disables timeout.
- CNT_W, $clog2(MEM_TIMEOUT+1) (min 1), wait-counter width, derived.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  opcode_t (6)  instruction opcode, valid from DECODE onward (IR output)
- funct  in  funct_t (6)  R-type function field
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- pcwrite, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca, jal  out  1 each  datapath controls
- pcen  out  1  pcwrite | (branch condition taken)
- alusrcb, pcsrc, aluop  out  2 each  mux selects / ALU op class
- fault  out  1  sticky error (illegal opcode or memory timeout)
- state_o  out  statetype_t (4)  current state, debug

Behaviour:
- Reset (async, reset_n=0): state=FETCH, wait counter=0, fault=0. All outputs are decoded from state, so only FETCH values hold: mem_req=1, alusrcb=01, every other control 0.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BEQEX, ADDIEX, ADDIWB, JEX, JALEX, JREX, FAULT.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite and pcwrite are asserted only in the cycle mem_ready=1; that cycle moves to DECODE.
  - Without mem_ready, the FSM stays in FETCH.
- DECODE: alusrcb=11, aluop=00. Next state by opcode:
  - LW/SW -> MEMADR; RTYPE with funct=JR -> JREX; other RTYPE -> RTYPEEX.
  - BEQ -> BEQEX; ADDI -> ADDIEX; J -> JEX; JAL -> JALEX.
  - Anything else -> FAULT.
- MEMADR: alusrca=1, alusrcb=10. LW -> MEMRD; SW -> MEMWR.
- MEMRD: mem_req=1, iord=1. On mem_ready -> MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
- MEMWR: mem_req=1, iord=1. memwrite is asserted only in the mem_ready cycle; that cycle -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
- ALUWB: regwrite=1, regdst=1 -> FETCH.
- BEQEX: alusrca=1, aluop=01, pcsrc=01; pcen=zero -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB: regwrite=1, regdst=0 -> FETCH.
- JEX: pcsrc=10, pcwrite=1 -> FETCH.
- JALEX: pcsrc=10, pcwrite=1, regwrite=1, jal=1 (datapath writes PC+4 to $31) -> FETCH.
- JREX: pcsrc=11, pcwrite=1 -> FETCH.
- Wait counter:
  - Cleared on entry to any mem_req state and whenever mem_ready=1.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - When MEM_TIMEOUT!=0 and the counter equals MEM_TIMEOUT-1 with mem_ready still 0, next state is FAULT.
  - mem_ready in that same cycle wins: normal transition, no fault.
  - Counter saturates; it never wraps.
- FAULT: absorbing state. fault=1, all write enables and mem_req are 0, selects are 00. Only reset_n exits.
- pcen = pcwrite | (branch & zero); branch is internal, asserted in BEQEX only.
- Reset asserted mid-access drops mem_req asynchronously; the in-flight access is abandoned.

Optional Feature:
- Macro MC_MAINDEC_BNE_EN.
- When defined:
  - OP_BNE (6'h05) decodes to BNEEX: alusrca=1, aluop=01, pcsrc=01, pcen=~zero.
  - statetype_t gains BNEEX.
- When undefined: BNE is illegal and goes DECODE->FAULT.

Decomposition:
- mips_decls_p (existing) gains statetype_t (4-bit enum, includes BNEEX, which is unused when the macro is off) and OP_BNE in opcode_t.
- The package already holds opcode_t, funct_t, F_JR, and the aluop constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
- One sub-module, mc_outdec: purely combinational statetype_t -> control vector.
- mc_maindec keeps the state register, next-state logic, wait counter, and the mem_ready gating of irwrite/pcwrite/memwrite.

Test Plan:
- Reset, then mem_ready tied 1; IR=LW (6'h23): states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH (5 cycles). irwrite pulses once; regwrite=1 and memtoreg=1 only in MEMWB.
- SW (6'h2b) with mem_ready delayed 3 cycles in MEMWR: memwrite=0 for 3 cycles, then exactly 1 cycle high, then FETCH.
- BEQ (6'h04): zero=1 gives pcen=1 in BEQEX; zero=0 gives pcen=0. RTYPE funct=6'h08 gives JREX with pcsrc=11, pcen=1.
- JAL (6'h03): JALEX with regwrite=1, jal=1, pcsrc=10, pcen=1.
- Illegal opcode 6'h3f: DECODE->FAULT, fault=1 held for 10+ cycles. reset_n=0 for one cycle returns to FETCH with fault=0.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH: FAULT after 4 FETCH cycles. A repeat run with mem_ready=1 on the 4th cycle gives DECODE and no fault.
